// File: rtl/accum_bank_ctrl_pkg.sv
// Shared constants for the accumulator bank controller: FSM state encodings,
// accumulator width and the default bank depth.
package accum_bank_ctrl_pkg;

  localparam int ACC_WIDTH          = 32;
  localparam int ACC_DEPTH_LOG2_DEF = 8;

  localparam logic [1:0] ACC_ST_IDLE  = 2'd0;
  localparam logic [1:0] ACC_ST_ACCUM = 2'd1;
  localparam logic [1:0] ACC_ST_DRAIN = 2'd2;
  localparam logic [1:0] ACC_ST_FIN   = 2'd3;

endpackage

// File: rtl/accum_bank_ctrl.sv
// Sequences the column accumulator banks for one GEMM output tile: K passes of
// overwrite/accumulate writes, then a valid/ready drain. Optional ACC_CTRL_PERF_EN adds a stall counter.
module accum_bank_ctrl
  import accum_bank_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = ACC_DEPTH_LOG2_DEF,
  parameter int KT_W       = 8,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DEPTH_LOG2:0]   cfg_rows,
  input  logic [KT_W-1:0]       cfg_k_tiles,
  input  logic                  psum_valid,
  output logic [DEPTH_LOG2-1:0] bank_addr,
  output logic                  bank_wr_en,
  output logic                  bank_acc_mode,
  output logic                  drain_valid,
  input  logic                  drain_ready,
  output logic                  drain_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  psum_err
`ifdef ACC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_stall_cnt
`endif
);

  localparam int RW = DEPTH_LOG2 + 1;
  localparam logic [RW-1:0] MAX_ROWS = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] row_cnt_q, row_cnt_d;
  logic [KT_W-1:0]       kt_cnt_q, kt_cnt_d;
  logic [RW-1:0]         rows_q, rows_d;
  logic [KT_W-1:0]       k_tiles_q, k_tiles_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  psum_err_q, psum_err_d;

  logic cfg_bad, start_ok, row_last, kt_last;

  assign cfg_bad  = (cfg_rows == '0) || (cfg_rows > MAX_ROWS) || (cfg_k_tiles == '0);
  assign start_ok = (state_q == ACC_ST_IDLE) && start && !cfg_bad;
  // Wrap is found by comparing against the latched row count, never by counter overflow.
  assign row_last = ({1'b0, row_cnt_q} == (rows_q - RW'(1)));
  assign kt_last  = (kt_cnt_q == (k_tiles_q - KT_W'(1)));

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    kt_cnt_d   = kt_cnt_q;
    rows_d     = rows_q;
    k_tiles_d  = k_tiles_q;
    cfg_err_d  = cfg_err_q;
    psum_err_d = psum_err_q;
    case (state_q)
      ACC_ST_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
            state_d   = ACC_ST_FIN;
          end else begin
            rows_d     = cfg_rows;
            k_tiles_d  = cfg_k_tiles;
            cfg_err_d  = 1'b0;
            psum_err_d = 1'b0;
            row_cnt_d  = '0;
            kt_cnt_d   = '0;
            state_d    = ACC_ST_ACCUM;
          end
        end
      end
      ACC_ST_ACCUM: begin
        if (psum_valid) begin
          if (row_last) begin
            row_cnt_d = '0;
            if (kt_last) state_d = ACC_ST_DRAIN;
            else         kt_cnt_d = kt_cnt_q + KT_W'(1);
          end else begin
            row_cnt_d = row_cnt_q + DEPTH_LOG2'(1);
          end
        end
      end
      ACC_ST_DRAIN: begin
        if (drain_ready) begin
          if (row_last) begin
            row_cnt_d = '0;
            state_d   = ACC_ST_FIN;
          end else begin
            row_cnt_d = row_cnt_q + DEPTH_LOG2'(1);
          end
        end
      end
      ACC_ST_FIN: state_d = ACC_ST_IDLE;
      default:    state_d = ACC_ST_IDLE;
    endcase
    if (psum_valid && (state_q != ACC_ST_ACCUM)) psum_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC_ST_IDLE;
      row_cnt_q  <= '0;
      kt_cnt_q   <= '0;
      rows_q     <= '0;
      k_tiles_q  <= '0;
      cfg_err_q  <= 1'b0;
      psum_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      kt_cnt_q   <= kt_cnt_d;
      rows_q     <= rows_d;
      k_tiles_q  <= k_tiles_d;
      cfg_err_q  <= cfg_err_d;
      psum_err_q <= psum_err_d;
    end
  end

  assign bank_addr     = row_cnt_q;
  assign bank_wr_en    = (state_q == ACC_ST_ACCUM) && psum_valid;
  assign bank_acc_mode = (state_q == ACC_ST_ACCUM) && (kt_cnt_q != '0);
  assign drain_valid   = (state_q == ACC_ST_DRAIN);
  assign drain_last    = drain_valid && row_last;
  assign busy          = (state_q != ACC_ST_IDLE);
  assign done          = (state_q == ACC_ST_FIN);
  assign cfg_err       = cfg_err_q;
  assign psum_err      = psum_err_q;

`ifdef ACC_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if (drain_valid && !drain_ready && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule
